baud_rate_gen: RTL and testbench

Free-running modulo-M counter producing a single-cycle sampling tick for the UART receiver and transmitter. The default configuration yields 16× oversampling of 19200 baud from a 50 MHz system clock. It sits between the system clock domain and the UART RX/TX state machines, which advance only on `TICK`. `Q` exposes the live count for debug and for the bench.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/mod_m_counter.sv | 43 ++++
 rtl/baud_rate_gen.sv | 40 ++++
 tb/tb_baud_rate_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Holds the default clock/baud/oversample settings plus the divisor and clog2
// helpers, so the baud generator and the RX/TX engines derive M and N the same way.
package uart_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned BAUD_RATE   = 19200;
    localparam int unsigned OVERSAMPLE  = 16;

    // Clocks per oversample tick: clk_hz / (baud * os), rounded to nearest.
    function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned os);
        longint unsigned den;
        longint unsigned num;
        den = longint'(baud) * longint'(os);
        num = longint'(clk_hz) + (den / 64'd2);
        return int'(num / den);
    endfunction

    // Smallest r such that 2^r >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned    r;
        longint unsigned v;
        r = 0;
        v = 64'd1;
        while (v < longint'(value)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a terminal-count decode.
// Ports:
//   CLK      - clock, rising edge
//   RESET    - asynchronous active-low reset
//   max_tick - high while q == M-1 (combinational decode of the register)
//   q        - current count, 0..M-1
module mod_m_counter
    import uart_pkg::*;
#(
    parameter int unsigned M = 163,
    parameter int unsigned N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    output logic         max_tick,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] Last = N'(M - 1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Wrap is an explicit compare, so M == 2^N behaves the same as any other M.
    always_comb begin
        q_d = q_q + N'(1);
        if (q_q == Last) begin
            q_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign max_tick = (q_q == Last);

endmodule

// File: rtl/baud_rate_gen.sv
// Oversampling tick generator for the UART RX/TX state machines.
// Produces a one-cycle TICK every M clocks, M derived from the clock and baud settings.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - asynchronous active-low reset
//   TICK  - one-cycle pulse every M clocks (while Q == M-1)
//   Q     - live counter value, 0..M-1
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = uart_pkg::CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = uart_pkg::BAUD_RATE,
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int unsigned M           = calc_divisor(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE),
    parameter int unsigned N           = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    output logic         TICK,
    output logic [N-1:0] Q
);

    localparam longint unsigned MaxCount = 64'd1 << N;

    // Reject divisors the counter cannot represent or that would never toggle.
    if ((M < 2) || (longint'(M) > MaxCount)) begin : g_bad_params
        $error("baud_rate_gen: M=%0d out of range for N=%0d", M, N);
    end

    mod_m_counter #(
        .M (M),
        .N (N)
    ) u_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .max_tick (TICK),
        .q        (Q)
    );

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: default (M=163) instance plus an M=4, N=2 instance.
module tb_baud_rate_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic [7:0] q;
    logic       tick4;
    logic [1:0] q4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    baud_rate_gen u_dut (
        .CLK   (clk),
        .RESET (rst_n),
        .TICK  (tick),
        .Q     (q)
    );

    baud_rate_gen #(
        .M (4),
        .N (2)
    ) u_dut4 (
        .CLK   (clk),
        .RESET (rst_n),
        .TICK  (tick4),
        .Q     (q4)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #5;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (q !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_q: got %0d expected 0", q);
            end
            n_cmp++;
            if (tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_tick: got %b expected 0", tick);
            end
            #10;
        end
    endtask

    task automatic test_count();
        int exp_q;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 163; k++) begin
            @(posedge clk);
            #1;
            exp_q = k % 163;
            n_cmp++;
            if (q !== 8'(exp_q)) begin
                n_fail++;
                $display("FAIL count_q edge %0d: got %0d expected %0d", k, q, exp_q);
            end
            n_cmp++;
            if (tick !== (exp_q == 162)) begin
                n_fail++;
                $display("FAIL count_tick edge %0d: got %b expected %b", k, tick, exp_q == 162);
            end
        end
    endtask

    task automatic test_periods();
        int  exp_q = 0;
        int  rises = 0;
        bit  prev_tick = 1'b0;
        bit  have_last = 1'b0;
        time last_rise = 0;
        for (int c = 0; c < 1630; c++) begin
            @(posedge clk);
            #1;
            exp_q = (exp_q == 162) ? 0 : exp_q + 1;
            n_cmp++;
            if (q !== 8'(exp_q)) begin
                n_fail++;
                $display("FAIL period_q cycle %0d: got %0d expected %0d", c, q, exp_q);
            end
            if (prev_tick) begin
                n_cmp++;
                if (tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_width cycle %0d: got %b expected 0", c, tick);
                end
            end
            if (tick === 1'b1 && !prev_tick) begin
                rises++;
                if (have_last) begin
                    n_cmp++;
                    if ($time - last_rise != 3260) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0t expected 3260", $time - last_rise);
                    end
                end
                have_last = 1'b1;
                last_rise = $time;
            end
            prev_tick = (tick === 1'b1);
        end
        n_cmp++;
        if (rises != 10) begin
            n_fail++;
            $display("FAIL tick_count: got %0d expected 10", rises);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int edges = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (q === 8'd100);
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_wait: got no Q=100 expected Q=100 within 200 edges");
        end
        #4;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_async_q: got %0d expected 0", q);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_tick: got %b expected 0", tick);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (q !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_hold_q: got %0d expected 0", q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            edges++;
            found = (tick === 1'b1);
        end
        n_cmp++;
        if (edges != 162 || !found) begin
            n_fail++;
            $display("FAIL mid_first_tick: got %0d edges expected 162", edges);
        end
        n_cmp++;
        if (q !== 8'd162) begin
            n_fail++;
            $display("FAIL mid_tick_q: got %0d expected 162", q);
        end
    endtask

    task automatic test_reset_during_tick();
        bit found;
        found = (tick === 1'b1);
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (tick === 1'b1);
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL tick_wait: got no TICK expected TICK within 400 edges");
        end
        #5;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_abort: got %b expected 0", tick);
        end
        n_cmp++;
        if (q !== 8'd0) begin
            n_fail++;
            $display("FAIL tick_abort_q: got %0d expected 0", q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 162; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (tick !== (k == 162)) begin
                n_fail++;
                $display("FAIL restart_tick edge %0d: got %b expected %b", k, tick, k == 162);
            end
            n_cmp++;
            if (q !== 8'(k)) begin
                n_fail++;
                $display("FAIL restart_q edge %0d: got %0d expected %0d", k, q, k);
            end
        end
    endtask

    task automatic test_small_m();
        int e;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (q4 !== 2'd0 || tick4 !== 1'b0) begin
            n_fail++;
            $display("FAIL m4_reset: got q=%0d tick=%b expected q=0 tick=0", q4, tick4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            e = k % 4;
            n_cmp++;
            if (q4 !== 2'(e)) begin
                n_fail++;
                $display("FAIL m4_q edge %0d: got %0d expected %0d", k, q4, e);
            end
            n_cmp++;
            if (tick4 !== (e == 3)) begin
                n_fail++;
                $display("FAIL m4_tick edge %0d: got %b expected %b", k, tick4, e == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_periods();
        test_reset_mid();
        test_reset_during_tick();
        test_small_m();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
